// File: rtl/multi_latch.sv
// multi_latch: bank of CHANNELS x WIDTH storage registers.
// Supports single-channel write, broadcast, and shift-in operations.
// Also provides per-channel change tracking, a saturating update counter,
// and a registered readback port that flags out-of-range channel selects.
module multi_latch #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  localparam int SW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_en,
  input  logic [1:0]                mode,
  input  logic [SW-1:0]             ch_sel,
  input  logic [WIDTH-1:0]          d,
  input  logic                      clr_changed,
  output logic [CHANNELS*WIDTH-1:0] q_all,
  output logic [WIDTH-1:0]          q_sel,
  output logic [CHANNELS-1:0]       changed,
  output logic [15:0]               upd_cnt,
  output logic                      sel_err
);

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_WRITE = 2'b01,
    MODE_BCAST = 2'b10,
    MODE_SHIFT = 2'b11
  } mode_e;

  // Counter saturates at all-ones instead of wrapping back to zero.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  mode_e               op;
  logic [CHANNELS-1:0] sel_hit;
  logic                sel_in_range;
  logic                wr_reject;
  logic                wr_accept;

  logic [WIDTH-1:0]    ch_q [CHANNELS];
  logic [WIDTH-1:0]    ch_d [CHANNELS];
  logic [CHANNELS-1:0] changed_q;
  logic [CHANNELS-1:0] changed_d;
  logic [15:0]         upd_cnt_q;
  logic [15:0]         upd_cnt_d;
  logic [WIDTH-1:0]    q_sel_q;
  logic [WIDTH-1:0]    q_sel_d;
  logic                sel_err_q;
  logic                sel_err_d;

  // Decode the select as a one-hot hit vector.
  // An empty hit vector means ch_sel points past the last channel.
  // This avoids indexing the register array with an out-of-range value.
  always_comb begin
    sel_hit = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      sel_hit[i] = (ch_sel == SW'(i));
    end
    sel_in_range = |sel_hit;
    op           = mode_e'(mode);
    wr_reject    = wr_en && (op == MODE_WRITE) && !sel_in_range;
    wr_accept    = wr_en && (op != MODE_HOLD) && !wr_reject;
  end

  // Next channel contents per operation.
  // Registers hold unless an operation is accepted.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      ch_d[i] = ch_q[i];
    end
    if (wr_accept) begin
      case (op)
        MODE_WRITE: begin
          for (int i = 0; i < CHANNELS; i++) begin
            if (sel_hit[i]) ch_d[i] = d;
          end
        end
        MODE_BCAST: begin
          for (int i = 0; i < CHANNELS; i++) begin
            ch_d[i] = d;
          end
        end
        MODE_SHIFT: begin
          ch_d[0] = d;
          for (int i = 1; i < CHANNELS; i++) begin
            ch_d[i] = ch_q[i-1];
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Sticky change flags.
  // The clear is applied first, then the set, so a set on the same edge wins.
  always_comb begin
    changed_d = clr_changed ? '0 : changed_q;
    for (int i = 0; i < CHANNELS; i++) begin
      if (ch_d[i] != ch_q[i]) changed_d[i] = 1'b1;
    end
  end

  // Update counter, readback mux and select-error pulse.
  // Readback always takes the pre-edge channel content.
  always_comb begin
    upd_cnt_d = wr_accept ? sat_inc(upd_cnt_q) : upd_cnt_q;
    q_sel_d   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (sel_hit[i]) q_sel_d = ch_q[i];
    end
    sel_err_d = wr_reject;
  end

  // State registers with synchronous active-low reset.
  // Reset overrides every other input on that edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        ch_q[i] <= '0;
      end
      changed_q <= '0;
      upd_cnt_q <= '0;
      q_sel_q   <= '0;
      sel_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        ch_q[i] <= ch_d[i];
      end
      changed_q <= changed_d;
      upd_cnt_q <= upd_cnt_d;
      q_sel_q   <= q_sel_d;
      sel_err_q <= sel_err_d;
    end
  end

  // Flatten the channel registers onto q_all without adding latency.
  for (genvar g = 0; g < CHANNELS; g++) begin : g_qall
    assign q_all[g*WIDTH +: WIDTH] = ch_q[g];
  end

  assign q_sel   = q_sel_q;
  assign changed = changed_q;
  assign upd_cnt = upd_cnt_q;
  assign sel_err = sel_err_q;

endmodule

// File: tb/tb_multi_latch.sv
// Directed-vector bench for multi_latch.
// Exercises the default 4x4 configuration and a 4-bit x 3-channel variant.
module tb_multi_latch;

  logic clk;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instance A: WIDTH=4, CHANNELS=4
  logic        a_rst_n, a_wr_en, a_clr;
  logic [1:0]  a_mode, a_sel;
  logic [3:0]  a_d, a_q_sel;
  logic [15:0] a_q_all, a_upd;
  logic [3:0]  a_changed;
  logic        a_sel_err;

  multi_latch #(.WIDTH(4), .CHANNELS(4)) dut_a (
    .clk(clk), .rst_n(a_rst_n), .wr_en(a_wr_en), .mode(a_mode),
    .ch_sel(a_sel), .d(a_d), .clr_changed(a_clr),
    .q_all(a_q_all), .q_sel(a_q_sel), .changed(a_changed),
    .upd_cnt(a_upd), .sel_err(a_sel_err)
  );

  // Instance B: WIDTH=4, CHANNELS=3
  logic        b_rst_n, b_wr_en, b_clr;
  logic [1:0]  b_mode, b_sel;
  logic [3:0]  b_d, b_q_sel;
  logic [11:0] b_q_all;
  logic [15:0] b_upd;
  logic [2:0]  b_changed;
  logic        b_sel_err;

  multi_latch #(.WIDTH(4), .CHANNELS(3)) dut_b (
    .clk(clk), .rst_n(b_rst_n), .wr_en(b_wr_en), .mode(b_mode),
    .ch_sel(b_sel), .d(b_d), .clr_changed(b_clr),
    .q_all(b_q_all), .q_sel(b_q_sel), .changed(b_changed),
    .upd_cnt(b_upd), .sel_err(b_sel_err)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_a(input logic wr, input logic [1:0] m, input logic [1:0] s,
                       input logic [3:0] dv, input logic c);
    a_wr_en = wr; a_mode = m; a_sel = s; a_d = dv; a_clr = c;
  endtask

  task automatic drv_b(input logic wr, input logic [1:0] m, input logic [1:0] s,
                       input logic [3:0] dv);
    b_wr_en = wr; b_mode = m; b_sel = s; b_d = dv; b_clr = 1'b0;
  endtask

  initial begin
    // Reset both instances while an operation is requested.
    a_rst_n = 1'b0; b_rst_n = 1'b0;
    drv_a(1'b1, 2'b10, 2'd0, 4'hF, 1'b0);
    drv_b(1'b1, 2'b10, 2'd0, 4'hF);
    step();
    chk("rst_q_all",   a_q_all,   16'h0000);
    chk("rst_changed", a_changed, 4'b0000);
    chk("rst_upd",     a_upd,     16'd0);
    chk("rst_q_sel",   a_q_sel,   4'h0);
    chk("rst_sel_err", a_sel_err, 1'b0);
    chk("b_rst_q_all", b_q_all,   12'h000);

    a_rst_n = 1'b1; b_rst_n = 1'b1;
    drv_a(1'b0, 2'b00, 2'd0, 4'h0, 1'b0);
    drv_b(1'b0, 2'b00, 2'd0, 4'h0);
    step();

    // ---------------- Instance B: out-of-range select ----------------
    drv_b(1'b1, 2'b01, 2'd1, 4'h7);
    step();
    chk("b_wr1_q_all", b_q_all, 12'h070);
    chk("b_wr1_upd",   b_upd,   16'd1);
    drv_b(1'b1, 2'b01, 2'd3, 4'hF);
    step();
    chk("b_bad_q_all",   b_q_all,   12'h070);
    chk("b_bad_upd",     b_upd,     16'd1);
    chk("b_bad_sel_err", b_sel_err, 1'b1);
    chk("b_bad_q_sel",   b_q_sel,   4'h0);
    drv_b(1'b0, 2'b00, 2'd1, 4'h0);
    step();
    chk("b_err_pulse_end", b_sel_err, 1'b0);
    chk("b_rd1_q_sel",     b_q_sel,   4'h7);
    drv_b(1'b0, 2'b01, 2'd3, 4'h0);
    step();
    chk("b_rd3_sel_err", b_sel_err, 1'b0);
    chk("b_rd3_q_sel",   b_q_sel,   4'h0);
    drv_b(1'b1, 2'b11, 2'd3, 4'h2);
    step();
    chk("b_shift_q_all",   b_q_all,   12'h702);
    chk("b_shift_upd",     b_upd,     16'd2);
    chk("b_shift_sel_err", b_sel_err, 1'b0);
    drv_b(1'b0, 2'b00, 2'd0, 4'h0);

    // ---------------- Instance A: write and readback ----------------
    drv_a(1'b1, 2'b01, 2'd2, 4'hA, 1'b0);
    step();
    chk("wr2_q_all",   a_q_all,   16'h0A00);
    chk("wr2_changed", a_changed, 4'b0100);
    chk("wr2_upd",     a_upd,     16'd1);
    chk("wr2_q_sel_old", a_q_sel, 4'h0);
    drv_a(1'b0, 2'b01, 2'd2, 4'h3, 1'b0);
    step();
    chk("rd2_q_sel",   a_q_sel,   4'hA);
    chk("noen_q_all",  a_q_all,   16'h0A00);
    chk("noen_upd",    a_upd,     16'd1);

    // Reset with a shift requested: everything returns to zero.
    a_rst_n = 1'b0;
    drv_a(1'b1, 2'b11, 2'd0, 4'h7, 1'b0);
    step();
    chk("rst2_q_all", a_q_all, 16'h0000);
    chk("rst2_upd",   a_upd,   16'd0);
    a_rst_n = 1'b1;

    // Broadcast then a four-step shift.
    drv_a(1'b1, 2'b10, 2'd1, 4'h5, 1'b0);
    step();
    chk("bc_q_all",   a_q_all,   16'h5555);
    chk("bc_changed", a_changed, 4'b1111);
    drv_a(1'b1, 2'b11, 2'd0, 4'h1, 1'b0);
    step();
    chk("sh1_q_all", a_q_all, 16'h5551);
    a_d = 4'h2; step();
    a_d = 4'h3; step();
    a_d = 4'h4; step();
    chk("sh4_q_all", a_q_all, 16'h1234);
    chk("sh4_upd",   a_upd,   16'd5);
    drv_a(1'b1, 2'b00, 2'd0, 4'hF, 1'b0);
    step();
    chk("hold_q_all", a_q_all, 16'h1234);
    chk("hold_upd",   a_upd,   16'd5);

    // Clear versus set on the same edge.
    drv_a(1'b1, 2'b01, 2'd0, 4'h9, 1'b1);
    step();
    chk("clr_set_changed", a_changed, 4'b0001);
    chk("clr_set_q_all",   a_q_all,   16'h1239);
    step();
    chk("clr_same_changed", a_changed, 4'b0000);
    chk("clr_same_upd",     a_upd,     16'd7);
    drv_a(1'b1, 2'b01, 2'd1, 4'h3, 1'b0);
    step();
    chk("rewrite_changed", a_changed, 4'b0000);
    drv_a(1'b1, 2'b01, 2'd1, 4'h6, 1'b0);
    step();
    chk("wr1_changed", a_changed, 4'b0010);
    drv_a(1'b0, 2'b00, 2'd3, 4'h0, 1'b1);
    step();
    chk("clr_idle_changed", a_changed, 4'b0000);
    chk("rd3_q_sel",        a_q_sel,   4'h1);

    // Readback on the same edge as a write returns the old value.
    drv_a(1'b1, 2'b01, 2'd3, 4'hE, 1'b0);
    step();
    chk("rdw_q_sel",  a_q_sel, 4'h1);
    chk("rdw_q_all",  a_q_all, 16'hE269);
    drv_a(1'b0, 2'b00, 2'd3, 4'h0, 1'b0);
    step();
    chk("rdw_q_sel_new", a_q_sel, 4'hE);

    // Reset in the middle of a shift burst.
    drv_a(1'b1, 2'b11, 2'd0, 4'h1, 1'b0);
    step();
    a_rst_n = 1'b0; a_d = 4'h2;
    step();
    chk("midrst_q_all", a_q_all, 16'h0000);
    a_rst_n = 1'b1; a_d = 4'h3;
    step();
    chk("postrst_q_all", a_q_all, 16'h0003);
    chk("postrst_upd",   a_upd,   16'd1);

    // Saturation: 65537 accepted updates since the last reset in total.
    drv_a(1'b1, 2'b10, 2'd0, 4'h0, 1'b0);
    for (int i = 0; i < 65533; i++) @(posedge clk);
    #1;
    chk("sat_fffe", a_upd, 16'hFFFE);
    step();
    chk("sat_ffff", a_upd, 16'hFFFF);
    step();
    step();
    chk("sat_nowrap", a_upd, 16'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multi_latch.md
MULTI_LATCH -- requirements
Module: multi_latch

Interface
REQ-001 Parameter WIDTH, default 4, data bits per channel (legal range 1..32).
REQ-002 Parameter CHANNELS, default 4, number of storage channels (legal range 2..16); SW = max(1, clog2(CHANNELS)).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low, sampled on rising clk edge.
REQ-005 wr_en  input  1  qualifies mode; no state change when 0, except for clr_changed and the q_sel/sel_err pipeline.
REQ-006 mode  input  2  operation: 00 HOLD, 01 WRITE, 10 BROADCAST, 11 SHIFT.
REQ-007 ch_sel  input  SW  channel index for WRITE and for readback.
REQ-008 d  input  WIDTH  write/shift-in data.
REQ-009 clr_changed  input  1  clears all changed flags.
REQ-010 q_all  output  CHANNELS*WIDTH  all channel contents, channel i at bits [i*WIDTH +: WIDTH].
REQ-011 q_sel  output  WIDTH  registered readback of channel ch_sel.
REQ-012 changed  output  CHANNELS  sticky per-channel "value changed" flags.
REQ-013 upd_cnt  output  16  saturating count of accepted update operations.
REQ-014 sel_err  output  1  one-cycle pulse flagging an out-of-range ch_sel.

Function
REQ-015 q_all shall be driven directly from channel registers (no added latency); a write is visible on q_all the cycle after the accepting edge.
REQ-016 HOLD, or any mode with wr_en=0: all channel registers shall keep their value.
REQ-017 WRITE with wr_en=1 and ch_sel<CHANNELS: channel ch_sel <= d; other channels hold.
REQ-018 BROADCAST with wr_en=1: every channel <= d; ch_sel is ignored.
REQ-019 SHIFT with wr_en=1: channel i <= channel i-1 for i=1..CHANNELS-1, channel 0 <= d; old channel CHANNELS-1 is discarded.
REQ-020 changed[i] shall set on any accepted operation where the new value of channel i differs from its old value; rewriting an equal value shall not set it.
REQ-021 clr_changed=1 shall clear all changed flags at the edge; if a set occurs on the same edge, set wins for that channel.
REQ-022 upd_cnt shall increment by 1 for each edge with wr_en=1 and mode!=HOLD that is not rejected under REQ-024, regardless of data change; it shall saturate at 16'hFFFF.
REQ-023 q_sel shall equal the pre-edge content of channel ch_sel, captured at each edge (1-cycle latency); on the same edge as a write to that channel it shall return the old value.
REQ-024 WRITE with wr_en=1 and ch_sel>=CHANNELS shall be rejected: no channel changes, no upd_cnt increment, sel_err=1 for exactly the following cycle.
REQ-025 ch_sel>=CHANNELS on any edge shall load q_sel with 0; sel_err shall assert only under REQ-024.
REQ-026 The block shall contain no latches or combinational loops; all storage is edge-triggered flip-flops.

Reset
REQ-027 rst_n=0 at a rising edge shall set all channels, q_sel, changed, upd_cnt and sel_err to 0, overriding all other inputs on that edge.
REQ-028 Reset asserted mid-operation (e.g. during a SHIFT burst) shall discard the in-flight operation; the first accepted operation after release shall see all channels at 0.

Verification
REQ-029 Reset with wr_en=1, mode=10, d=4'hF -> q_all=16'h0000, changed=0, upd_cnt=0, q_sel=0.
REQ-030 WRITE ch 2 d=4'hA, then read ch_sel=2 -> q_all=16'h0A00, changed=4'b0100, upd_cnt=1; q_sel=4'hA one cycle after read edge.
REQ-031 BROADCAST 4'h5, then SHIFT d=1,2,3,4 on 4 consecutive cycles -> q_all=16'h1234 (ch3=1, ch0=4); upd_cnt=5.
REQ-032 With WIDTH=4, CHANNELS=3: WRITE ch_sel=3 -> q_all unchanged, upd_cnt unchanged, sel_err high exactly 1 cycle, q_sel=0.
REQ-033 clr_changed=1 together with WRITE ch 0 of a differing value -> changed=4'b0001 after edge; rewrite same value with clr_changed=1 -> changed=0.
REQ-034 Force 65537 accepted updates -> upd_cnt holds 16'hFFFF, no wrap to 0.
